// File: rtl/exe_stage.sv
// exe_stage: execute stage with a single-cycle ALU, a 32-iteration radix-2 divider and the data-SRAM request
module exe_stage #(
  parameter int DS_TO_ES_BUS_WD = 255,
  parameter int ES_TO_MS_BUS_WD = 175,
  parameter int ES_TO_DS_BUS_WD = 39
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [5:0]                 stall,
  output logic                       stallreq_es,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_TO_DS_BUS_WD-1:0] es_to_ds_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_next;
  logic [DS_TO_ES_BUS_WD-1:0] r_bus;
  logic [5:0] r_cnt;
  logic [31:0] r_quo, r_rem, r_dvs;
  logic r_neg_q, r_neg_r;
  logic [63:0] w_csr;
  logic [5:0] w_load_op;
  logic [2:0] w_store_op;
  logic w_reg_we, w_signed, w_slt, w_sltu;
  logic [4:0] w_dest, w_sa;
  logic [11:0] w_alu_op;
  logic [3:0] w_div_op;
  logic [31:0] w_src1, w_src2, w_st_data, w_pc, w_inst;
  logic [31:0] w_alu, w_sra, w_qv, w_rv, w_result;
  logic [32:0] w_sh, w_sub;
  assign {w_csr, w_load_op, w_store_op, w_reg_we, w_dest, w_alu_op, w_div_op,
          w_src1, w_src2, w_st_data, w_pc, w_inst} = r_bus;
  always_ff @(posedge clk) begin
    if (reset | flush) r_bus <= '0;
    else if (stall[2] & ~stall[3]) r_bus <= '0;
    else if (~stall[2]) r_bus <= ds_to_es_bus;
  end
  assign w_sa   = w_src2[4:0];
  assign w_slt  = $signed(w_src1) < $signed(w_src2);
  assign w_sltu = w_src1 < w_src2;
  assign w_sra  = $signed(w_src1) >>> w_sa;
  assign w_alu = ({32{w_alu_op[0]}}  & (w_src1 + w_src2))
               | ({32{w_alu_op[1]}}  & (w_src1 - w_src2))
               | ({32{w_alu_op[2]}}  & {31'b0, w_slt})
               | ({32{w_alu_op[3]}}  & {31'b0, w_sltu})
               | ({32{w_alu_op[4]}}  & (w_src1 & w_src2))
               | ({32{w_alu_op[5]}}  & (w_src1 | w_src2))
               | ({32{w_alu_op[6]}}  & ~(w_src1 | w_src2))
               | ({32{w_alu_op[7]}}  & (w_src1 ^ w_src2))
               | ({32{w_alu_op[8]}}  & (w_src1 << w_sa))
               | ({32{w_alu_op[9]}}  & (w_src1 >> w_sa))
               | ({32{w_alu_op[10]}} & w_sra)
               | ({32{w_alu_op[11]}} & w_src2);
  assign w_signed = w_div_op[0] | w_div_op[2];
  assign w_sh  = {r_rem, r_quo[31]};
  assign w_sub = w_sh - {1'b0, r_dvs};
  always_comb begin
    w_next = (r_state == IDLE && |w_div_op)   ? BUSY :
             (r_state == BUSY && r_cnt == 6'd31) ? DONE :
             (r_state == DONE && !stall[2])    ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset | flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && |w_div_op) begin
        r_quo   <= (w_signed & w_src1[31]) ? -w_src1 : w_src1;
        r_dvs   <= (w_signed & w_src2[31]) ? -w_src2 : w_src2;
        r_rem   <= '0;
        r_cnt   <= '0;
        r_neg_q <= w_signed & (w_src1[31] ^ w_src2[31]);
        r_neg_r <= w_signed & w_src1[31];
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt + 6'd1;
        r_rem <= w_sub[32] ? w_sh[31:0] : w_sub[31:0];
        r_quo <= {r_quo[30:0], ~w_sub[32]};
      end
    end
  end
  assign w_qv = r_neg_q ? -r_quo : r_quo;
  assign w_rv = r_neg_r ? -r_rem : r_rem;
  assign w_result = ~|w_div_op ? w_alu : (w_div_op[0] | w_div_op[1]) ? w_qv : w_rv;
  assign stallreq_es = (|w_div_op && r_state == IDLE) || r_state == BUSY;
  assign es_to_ms_bus = stallreq_es ? '0 :
    {w_csr, w_load_op, w_store_op, w_reg_we, w_dest, w_result, w_pc, w_inst};
  assign es_to_ds_bus = {|w_load_op, w_reg_we & ~stallreq_es, w_dest, w_result};
  assign data_sram_addr = w_result;
  assign data_sram_en = (|w_load_op | |w_store_op) & ~flush;
  assign data_sram_we = (flush | ~|w_store_op) ? 4'b0000 :
                        w_store_op[0] ? (4'b0001 << w_result[1:0]) :
                        w_store_op[1] ? (w_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign data_sram_wdata = w_store_op[0] ? {4{w_st_data[7:0]}} :
                           w_store_op[1] ? {2{w_st_data[15:0]}} : w_st_data;
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed and randomized checks of exe_stage against a behavioural model
module tb_exe_stage;
  logic clk = 1'b0;
  logic reset, flush, stallreq_es, data_sram_en;
  logic [5:0] stall, ext_stall;
  logic [254:0] ds_to_es_bus;
  logic [174:0] es_to_ms_bus, exp_a;
  logic [38:0] es_to_ds_bus;
  logic [3:0] data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] l_csr;
  logic [31:0] l_pc, l_inst;
  logic [5:0] l_ld;
  logic [2:0] l_st;
  logic l_we;
  logic [4:0] l_dst;

  exe_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall), .stallreq_es(stallreq_es),
    .ds_to_es_bus(ds_to_es_bus), .es_to_ms_bus(es_to_ms_bus), .es_to_ds_bus(es_to_ds_bus),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
  );

  always #5 clk = ~clk;
  assign stall = stallreq_es ? (ext_stall | 6'b001111) : ext_stall;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [174:0] obs, input logic [174:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] ld, input logic [2:0] st, input logic we,
                       input logic [11:0] alu, input logic [3:0] dv,
                       input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] sd);
    l_csr = {$urandom, $urandom};
    l_pc = $urandom;
    l_inst = $urandom;
    l_dst = 5'($urandom);
    l_ld = ld;
    l_st = st;
    l_we = we;
    ds_to_es_bus = {l_csr, ld, st, we, l_dst, alu, dv, s1, s2, sd, l_pc, l_inst};
  endtask

  function automatic logic [174:0] ms_exp(input logic [31:0] res);
    return {l_csr, l_ld, l_st, l_we, l_dst, res, l_pc, l_inst};
  endfunction

  function automatic logic [31:0] alu_ref(input int k, input logic [31:0] a, input logic [31:0] b);
    case (k)
      0: return a + b;
      1: return a - b;
      2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3: return (a < b) ? 32'd1 : 32'd0;
      4: return a & b;
      5: return a | b;
      6: return ~(a | b);
      7: return a ^ b;
      8: return a << b[4:0];
      9: return a >> b[4:0];
      10: return $signed(a) >>> b[4:0];
      11: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] div_ref(input int k, input logic [31:0] a, input logic [31:0] b);
    logic sg;
    logic [31:0] ma, mb, q, r;
    sg = (k == 0 || k == 2);
    ma = (sg && a[31]) ? -a : a;
    mb = (sg && b[31]) ? -b : b;
    if (mb == 32'd0) begin
      q = 32'hFFFFFFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (sg && a[31] != b[31]) q = -q;
    if (sg && a[31]) r = -r;
    return (k < 2) ? q : r;
  endfunction

  task automatic run_div(input int k, input logic [31:0] a, input logic [31:0] b);
    int n, bad;
    logic [31:0] e;
    e = div_ref(k, a, b);
    issue(6'b0, 3'b0, 1'b1, 12'b0, 4'(1 << k), a, b, 32'h0);
    tick();
    ds_to_es_bus = '0;
    n = 0;
    bad = 0;
    while (stallreq_es && n < 100) begin
      if (es_to_ms_bus !== '0 || es_to_ds_bus[37] !== 1'b0) bad++;
      n++;
      tick();
    end
    chk("div_stall_cycles", 175'(n), 175'(33));
    chk("div_bubble_during_stall", 175'(bad), '0);
    chk("div_result", es_to_ms_bus, ms_exp(e));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    logic [31:0] a, b;
    reset = 1'b1;
    flush = 1'b0;
    ext_stall = '0;
    ds_to_es_bus = '0;
    tick();
    tick();
    chk("rst_ms_bus", es_to_ms_bus, '0);
    chk("rst_ds_bus", 175'(es_to_ds_bus), '0);
    chk("rst_sram", 175'({data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata}), '0);
    chk("rst_stallreq", 175'(stallreq_es), '0);
    reset = 1'b0;
    issue(6'b0, 3'b0, 1'b1, 12'h001, 4'b0, 32'd5, 32'd7, 32'd0);
    tick();
    chk("add_ms_bus", es_to_ms_bus, ms_exp(32'd12));
    chk("add_ds_bus", 175'(es_to_ds_bus), 175'({1'b0, 1'b1, l_dst, 32'd12}));
    chk("add_no_sram", 175'({data_sram_en, data_sram_we}), '0);
    issue(6'b0, 3'b001, 1'b0, 12'h001, 4'b0, 32'h1000, 32'd3, 32'hAB);
    tick();
    chk("st_b", 175'({data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata}),
        175'({1'b1, 4'b1000, 32'h1003, 32'hABABABAB}));
    issue(6'b0, 3'b010, 1'b0, 12'h001, 4'b0, 32'h1000, 32'd2, 32'h5A5A1234);
    tick();
    chk("st_h_hi", 175'({data_sram_en, data_sram_we, data_sram_wdata}), 175'({1'b1, 4'b1100, 32'h12341234}));
    issue(6'b0, 3'b010, 1'b0, 12'h001, 4'b0, 32'h1000, 32'd0, 32'h0000BEEF);
    tick();
    chk("st_h_lo", 175'({data_sram_en, data_sram_we, data_sram_wdata}), 175'({1'b1, 4'b0011, 32'hBEEFBEEF}));
    issue(6'b0, 3'b100, 1'b0, 12'h001, 4'b0, 32'h2000, 32'd4, 32'hDEADBEEF);
    tick();
    chk("st_w", 175'({data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata}),
        175'({1'b1, 4'b1111, 32'h2004, 32'hDEADBEEF}));
    flush = 1'b1;
    #1;
    chk("st_w_flush", 175'({data_sram_en, data_sram_we}), '0);
    tick();
    flush = 1'b0;
    chk("flush_clears_reg", es_to_ms_bus, '0);
    issue(6'b000001, 3'b0, 1'b1, 12'h001, 4'b0, 32'h3000, 32'd8, 32'd0);
    tick();
    chk("load_sram", 175'({data_sram_en, data_sram_we, data_sram_addr}), 175'({1'b1, 4'b0000, 32'h3008}));
    chk("load_fwd", 175'(es_to_ds_bus[38:37]), 175'(2'b11));
    issue(6'b0, 3'b0, 1'b1, 12'h000, 4'b0, 32'h1234, 32'h5678, 32'd0);
    tick();
    chk("alu_none", es_to_ms_bus, ms_exp(32'd0));
    for (int i = 0; i < 24; i++) begin
      k = int'($urandom_range(0, 11));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      issue(6'b0, 3'b0, 1'b1, 12'(1 << k), 4'b0, a, b, 32'd0);
      tick();
      chk("alu_rand", es_to_ms_bus, ms_exp(alu_ref(k, a, b)));
    end
    run_div(0, -32'sd7, 32'd2);
    run_div(2, -32'sd7, 32'd2);
    run_div(1, 32'd9, 32'd0);
    run_div(3, 32'd9, 32'd0);
    run_div(0, 32'h80000000, 32'hFFFFFFFF);
    run_div(2, 32'h80000000, 32'hFFFFFFFF);
    for (int i = 0; i < 6; i++) run_div(int'($urandom_range(0, 3)), $urandom, 32'($urandom_range(1, 1000)));
    issue(6'b0, 3'b0, 1'b1, 12'b0, 4'b0001, 32'd1000, 32'd3, 32'd0);
    tick();
    ds_to_es_bus = '0;
    repeat (10) tick();
    chk("busy_before_flush", 175'(stallreq_es), 175'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_stallreq", 175'(stallreq_es), '0);
    chk("flush_ms_bus", es_to_ms_bus, '0);
    chk("flush_ds_bus", 175'(es_to_ds_bus), '0);
    issue(6'b0, 3'b0, 1'b1, 12'h001, 4'b0, 32'd20, 32'd22, 32'd0);
    tick();
    chk("add_after_flush", es_to_ms_bus, ms_exp(32'd42));
    issue(6'b0, 3'b0, 1'b1, 12'b0, 4'b0010, 32'd100, 32'd7, 32'd0);
    tick();
    ds_to_es_bus = '0;
    for (int n = 0; n < 100 && stallreq_es; n++) tick();
    ext_stall = 6'b011111;
    exp_a = ms_exp(32'd14);
    repeat (3) begin
      tick();
      chk("done_hold", es_to_ms_bus, exp_a);
    end
    chk("done_no_stallreq", 175'(stallreq_es), '0);
    ext_stall = '0;
    tick();
    chk("done_release", es_to_ms_bus, '0);
    issue(6'b0, 3'b0, 1'b1, 12'h001, 4'b0, 32'd1, 32'd2, 32'd0);
    tick();
    exp_a = ms_exp(32'd3);
    issue(6'b0, 3'b0, 1'b1, 12'h001, 4'b0, 32'd100, 32'd200, 32'd0);
    ext_stall = 6'b001111;
    tick();
    chk("hold_reg", es_to_ms_bus, exp_a);
    ext_stall = 6'b000111;
    tick();
    chk("bubble", es_to_ms_bus, '0);
    ext_stall = '0;
    tick();
    chk("load_after_bubble", es_to_ms_bus, ms_exp(32'd300));
    issue(6'b0, 3'b0, 1'b1, 12'b0, 4'b1000, 32'd50, 32'd5, 32'd0);
    tick();
    ds_to_es_bus = '0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midbusy_rst_ms", es_to_ms_bus, '0);
    chk("midbusy_rst_ds", 175'(es_to_ds_bus), '0);
    chk("midbusy_rst_sram", 175'({data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata}), '0);
    chk("midbusy_rst_stallreq", 175'(stallreq_es), '0);
    run_div(3, 32'd50, 32'd7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
